axi_read_arbiter: RTL

Shares the single AXI read master port (AR and R channels) between two requesters: requester 0 is instruction fetch and requester 1 is data load. Bursts are issued one at a time, and the granted requester's data beats are steered back to it. The block sits between the core's fetch/load units and the `m_axi_ar*`/`m_axi_r*` bus ports. Requester selection is round-robin by default; fixed priority is available at compile time.

---
 rtl/axi_read_arbiter_if.sv | 41 ++++
 rtl/axi_read_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter_if.sv
// AXI read-only bus bundle (AR + R channels) between the arbiter and the
// downstream slave.
interface axi_read_arbiter_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter, one burst in flight; round-robin by
// default, fixed priority (requester 0) when AXI_RDARB_FIXED_PRIO_EN is set.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]             req_len,
    input  logic [3:0]              req_burst,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_last,
    output logic                    rsp_err,
    output logic                    id_err,
    axi_read_arbiter_if.master      m_axi
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [1:0]            arburst_q, arburst_d;
    logic [2:0]            arsize_q, arsize_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  id_err_q, id_err_d;

    logic win;
    logic beat;
    logic id_ok;
    logic hit;
    logic done;
    logic unused_rresp0;

    assign beat  = m_axi.rvalid & rready_q;
    assign id_ok = m_axi.rid == {{(ID_WIDTH-1){1'b0}}, grant_q};
    assign hit   = beat & id_ok;
    assign done  = (state_q == DATA) & hit & m_axi.rlast;

`ifdef AXI_RDARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks.
    assign win = ~req_valid[0];
`else
    logic rr_q, rr_d;

    assign win  = (req_valid == 2'b11) ? rr_q : req_valid[1];
    assign rr_d = done ? ~grant_q : rr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        req_ready = 2'b00;
        if (state_q == IDLE && |req_valid) begin
            req_ready = win ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arburst_d = arburst_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        id_err_d  = id_err_q | (beat & ~id_ok);
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d   = win;
                    araddr_d  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : req_addr[ADDR_WIDTH-1:0];
                    arlen_d   = win ? req_len[15:8] : req_len[7:0];
                    arburst_d = win ? req_burst[3:2] : req_burst[1:0];
                    arsize_d  = 3'b011;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (done) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            id_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arburst_q <= arburst_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            id_err_q  <= id_err_d;
        end
    end

    assign m_axi.arid    = {{(ID_WIDTH-1){1'b0}}, grant_q};
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = arsize_q;
    assign m_axi.arburst = arburst_q;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    // Mismatched-ID beats are swallowed: no strobe, last or error escapes.
    assign rsp_valid = hit ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = m_axi.rdata;
    assign rsp_last  = hit & m_axi.rlast;
    assign rsp_err   = hit & m_axi.rresp[1];
    assign id_err    = id_err_q;

    assign unused_rresp0 = m_axi.rresp[0];

endmodule
